// File: rtl/mult_special_result_unit.sv
// ---------------------------------------------------------------------------
// mult_special_result_unit
//
// Wraps a floating-point multiplier datapath and short-circuits IEEE-754
// special operands (zero, infinity, NaN). A request is captured in IDLE and
// the operands are classified for one cycle. A special product is then
// produced locally. Any other product is taken from the external normal
// datapath when it reports a valid result.
//
// Parameters
//   W            operand/result width, 32 (EW=8, SW=23) or 64 (EW=11, SW=52)
//
// Ports
//   clk          clock, all state changes on the rising edge
//   rst          synchronous active-high reset
//   start        request, accepted only while ready=1
//   Data_A       operand A {sign, exponent, mantissa}
//   Data_B       operand B {sign, exponent, mantissa}
//   norm_valid   normal datapath result valid this cycle
//   norm_result  normal datapath result
//   ready        high only in IDLE
//   done         one-cycle pulse, result and flags valid
//   result       final product word, held until the next done
//   special_flag result came from the special-case path
//   zero_flag    special result is a signed zero
//   inf_flag     special result is a signed infinity
//   nan_flag     special result is the canonical quiet NaN
//
// States
//   state      | meaning
//   IDLE       | ready for a request, operands captured on start
//   CLASSIFY   | inspect registered operands, pick special or normal path
//   SPEC_OUT   | special result on the outputs, done asserted
//   WAIT_NORM  | waiting for the normal datapath result
// ---------------------------------------------------------------------------
module mult_special_result_unit #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] Data_A,
    input  logic [W-1:0] Data_B,
    input  logic         norm_valid,
    input  logic [W-1:0] norm_result,
    output logic         ready,
    output logic         done,
    output logic [W-1:0] result,
    output logic         special_flag,
    output logic         zero_flag,
    output logic         inf_flag,
    output logic         nan_flag
);

    localparam int EW = (W == 64) ? 11 : 8;
    localparam int SW = W - 1 - EW;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CLASSIFY  = 2'd1,
        SPEC_OUT  = 2'd2,
        WAIT_NORM = 2'd3
    } state_t;

    state_t         state_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [W-1:0]   result_q;
    logic           done_q;
    logic           special_q;
    logic           zero_q;
    logic           inf_q;
    logic           nan_q;

    logic           a_zero, a_inf, a_nan;
    logic           b_zero, b_inf, b_nan;
    logic           is_nan_d, is_inf_d, is_zero_d, any_special_d;
    logic           sign_d;
    logic [W-1:0]   spec_result_d;

    // Operand classification from the registered copies. Subnormals
    // (exponent 0, mantissa nonzero) fall through as non-special.
    always_comb begin
        a_zero = (a_q[W-2 -: EW] == '0)        && (a_q[SW-1:0] == '0);
        a_inf  = (a_q[W-2 -: EW] == {EW{1'b1}}) && (a_q[SW-1:0] == '0);
        a_nan  = (a_q[W-2 -: EW] == {EW{1'b1}}) && (a_q[SW-1:0] != '0);
        b_zero = (b_q[W-2 -: EW] == '0)        && (b_q[SW-1:0] == '0);
        b_inf  = (b_q[W-2 -: EW] == {EW{1'b1}}) && (b_q[SW-1:0] == '0);
        b_nan  = (b_q[W-2 -: EW] == {EW{1'b1}}) && (b_q[SW-1:0] != '0);
    end

    // Priority NaN > Inf > Zero; zero times infinity is invalid and yields NaN.
    always_comb begin
        sign_d        = a_q[W-1] ^ b_q[W-1];
        is_nan_d      = a_nan | b_nan | (a_zero & b_inf) | (a_inf & b_zero);
        is_inf_d      = ~is_nan_d & (a_inf | b_inf);
        is_zero_d     = ~is_nan_d & ~is_inf_d & (a_zero | b_zero);
        any_special_d = is_nan_d | is_inf_d | is_zero_d;

        spec_result_d = {sign_d, {EW{1'b0}}, {SW{1'b0}}};
        if (is_nan_d) begin
            // Canonical quiet NaN always carries a positive sign.
            spec_result_d = {1'b0, {EW{1'b1}}, 1'b1, {(SW-1){1'b0}}};
        end else if (is_inf_d) begin
            spec_result_d = {sign_d, {EW{1'b1}}, {SW{1'b0}}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            result_q  <= '0;
            done_q    <= 1'b0;
            special_q <= 1'b0;
            zero_q    <= 1'b0;
            inf_q     <= 1'b0;
            nan_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= Data_A;
                        b_q     <= Data_B;
                        state_q <= CLASSIFY;
                    end
                end
                CLASSIFY: begin
                    if (any_special_d) begin
                        result_q  <= spec_result_d;
                        special_q <= 1'b1;
                        nan_q     <= is_nan_d;
                        inf_q     <= is_inf_d;
                        zero_q    <= is_zero_d;
                        done_q    <= 1'b1;
                        state_q   <= SPEC_OUT;
                    end else begin
                        state_q <= WAIT_NORM;
                    end
                end
                SPEC_OUT: begin
                    state_q <= IDLE;
                end
                WAIT_NORM: begin
                    if (norm_valid) begin
                        result_q  <= norm_result;
                        special_q <= 1'b0;
                        nan_q     <= 1'b0;
                        inf_q     <= 1'b0;
                        zero_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready        = (state_q == IDLE);
    assign done         = done_q;
    assign result       = result_q;
    assign special_flag = special_q;
    assign zero_flag    = zero_q;
    assign inf_flag     = inf_q;
    assign nan_flag     = nan_q;

endmodule
